// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/execute/writeback sequencer for the single-issue RV32 core.
// Owns the PC and instruction register; halts on ebreak until reset.
module exec_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] PC_INCREMENT = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        exec_valid,
  output logic        rf_wen,
  output logic        halted,
  output logic [31:0] retire_cnt
);

  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    EXEC,
    WB,
    HALT
  } state_t;

  state_t state;
  logic   capture;

  // A word is taken either on a granted request that returns in the same
  // cycle, or on the first rvalid while a granted fetch is outstanding.
  assign capture   = ((state == FETCH) && imem_gnt && imem_rvalid) ||
                     ((state == WAIT) && imem_rvalid);

  assign imem_addr = pc;

  // Control outputs are registered alongside the state so they never depend
  // combinationally on the memory inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR;
      inst       <= NOP_WORD;
      retire_cnt <= '0;
      imem_req   <= 1'b1;
      exec_valid <= 1'b0;
      rf_wen     <= 1'b0;
      halted     <= 1'b0;
    end else if (capture) begin
      inst     <= imem_rdata;
      imem_req <= 1'b0;
      if (imem_rdata == EBREAK_WORD) begin
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        state      <= EXEC;
        exec_valid <= 1'b1;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
        end
        EXEC: begin
          state      <= WB;
          exec_valid <= 1'b0;
          rf_wen     <= 1'b1;
        end
        WB: begin
          state      <= FETCH;
          rf_wen     <= 1'b0;
          imem_req   <= 1'b1;
          pc         <= pc + PC_INCREMENT;
          retire_cnt <= retire_cnt + 32'd1;
        end
        HALT: begin
        end
        default: begin
          state      <= FETCH;
          imem_req   <= 1'b1;
          exec_valid <= 1'b0;
          rf_wen     <= 1'b0;
          halted     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed test-plan scenarios followed
// by randomized memory timing, all checked every cycle against a phase model.
module tb_exec_sequencer;

  localparam logic [31:0] RV     = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        exec_valid;
  logic        rf_wen;
  logic        halted;
  logic [31:0] retire_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  // Model: age counts cycles since a non-ebreak capture (1 = execute cycle,
  // 2 = writeback cycle, 0 = fetching); outstanding marks a granted fetch.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cnt;
  logic        m_halted;
  logic        m_outstanding;
  int          m_age;

  exec_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .inst        (inst),
    .exec_valid  (exec_valid),
    .rf_wen      (rf_wen),
    .halted      (halted),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic m_req();
    return !m_halted && (m_age == 0) && !m_outstanding;
  endfunction

  function automatic logic [31:0] rand_addi();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = 7'b0010011;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic modelStep(input logic r, input logic g, input logic v, input logic [31:0] d);
    logic take;
    if (r) begin
      m_pc = RV; m_inst = NOP; m_cnt = 0; m_halted = 0; m_outstanding = 0; m_age = 0;
    end else if (!m_halted) begin
      if (m_age == 1) m_age = 2;
      else if (m_age == 2) begin
        m_pc = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
        m_age = 0;
      end else begin
        take = (m_outstanding && v) || (!m_outstanding && g && v);
        if (!m_outstanding && g && !v) m_outstanding = 1;
        if (take) begin
          m_inst = d;
          m_outstanding = 0;
          if (d == EBREAK) m_halted = 1;
          else m_age = 1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    check("imem_req", imem_req, m_req());
    if (m_req()) check("imem_addr", imem_addr, m_pc);
    check("exec_valid", exec_valid, m_age == 1);
    check("rf_wen", rf_wen, m_age == 2);
    check("halted", halted, m_halted);
    check("pc", pc, m_pc);
    check("inst", inst, m_inst);
    check("retire_cnt", retire_cnt, m_cnt);
  endtask

  // Inputs change at the falling edge, the model advances with the rising
  // edge, and outputs are compared at the next falling edge.
  task automatic applyStimulus(input logic r, input logic g, input logic v, input logic [31:0] d);
    rst = r; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    @(posedge clk);
    modelStep(r, g, v, d);
    @(negedge clk);
    cycle++;
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic zeroWait(input logic [31:0] w);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, w);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check("zw_rf_wen_lit", rf_wen, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic        r, g, v;
    logic [31:0] d;
    logic [31:0] word;
    int          halt_cycles;

    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);

    doReset();
    check("rst_pc_lit", pc, 32'h8000_0000);
    check("rst_inst_lit", inst, 32'h0000_0013);
    check("rst_cnt_lit", retire_cnt, 32'd0);
    check("rst_req_lit", imem_req, 1'b1);
    check("rst_wen_lit", rf_wen, 1'b0);
    check("rst_halted_lit", halted, 1'b0);

    zeroWait(32'h0010_0093);
    zeroWait(32'h0020_0113);
    zeroWait(32'h0030_0193);
    check("zw_pc_lit", pc, 32'h8000_000C);
    check("zw_cnt_lit", retire_cnt, 32'd3);

    doReset();
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      check("stall_req_lit", imem_req, 1'b1);
      check("stall_addr_lit", imem_addr, 32'h8000_0000);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0213);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check("stall_pc_lit", pc, 32'h8000_0004);
    check("stall_cnt_lit", retire_cnt, 32'd1);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0010_0093);
    check("same_exec_lit", exec_valid, 1'b1);
    check("same_inst_lit", inst, 32'h0010_0093);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check("same_wen_lit", rf_wen, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check("same_pc_lit", pc, 32'h8000_0008);

    doReset();
    zeroWait(rand_addi());
    zeroWait(rand_addi());
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, EBREAK);
    check("ebrk_halted_lit", halted, 1'b1);
    check("ebrk_pc_lit", pc, 32'h8000_0008);
    check("ebrk_cnt_lit", retire_cnt, 32'd2);
    repeat (20) applyStimulus(1'b0, 1'($urandom), 1'($urandom), $urandom);
    check("ebrk_req_lit", imem_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check("ebrk_rst_pc_lit", pc, 32'h8000_0000);
    check("ebrk_rst_halted_lit", halted, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check("midwait_pc_lit", pc, 32'h8000_0000);
    check("midwait_inst_lit", inst, 32'h0000_0013);
    check("midwait_req_lit", imem_req, 1'b1);
    check("midwait_wen_lit", rf_wen, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Random memory timing, occasional ebreak and asynchronous-looking resets.
    halt_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      word = ($urandom_range(0, 19) == 0) ? EBREAK : rand_addi();
      r = ($urandom_range(0, 299) == 0) || (m_halted && halt_cycles >= 12);
      halt_cycles = m_halted ? halt_cycles + 1 : 0;
      if (m_req()) begin
        g = ($urandom_range(0, 2) != 0);
        v = g && ($urandom_range(0, 2) == 0);
        d = v ? word : $urandom;
      end else if (m_outstanding) begin
        g = 1'b0;
        v = $urandom_range(0, 1) == 1;
        d = word;
      end else begin
        g = 1'b0;
        v = ($urandom_range(0, 3) == 0);
        d = $urandom;
      end
      applyStimulus(r, g, v, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
